// File: rtl/ativiade5_mem_test_master_if.sv
// Avalon-MM bus bundle between the memory test master and the on-chip RAM slave (s1).
// Latency: none, this file only groups signals.
// Backpressure: avm_waitrequest from the slave stalls the master.
// Ports: master drives address/byteenable/chipselect/write/writedata/clken and
//        receives readdata/waitrequest; slave is the mirror image.
interface ativiade5_mem_test_master_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/ativiade5_mem_test_master.sv
// Memory self-test master: fills [base, base+length) with a pattern, reads it back, counts mismatches.
// Latency: one word per cycle when not stalled; readback compared READ_LATENCY cycles after issue.
// Backpressure: avm_waitrequest holds address/data/command stable until the slave accepts.
// Ports: i_clk/i_reset (sync, active-high), i_start + i_base_addr/i_length/i_seed test request,
//        o_busy/o_done/o_pass/o_range_err/o_err_count/o_first_err_addr status, avm master bus.
// Build option: define MEMTEST_LFSR_EN for a 32-bit Galois LFSR pattern (poly 0x80200003);
//        otherwise each word is its zero-extended address XOR seed.
module ativiade5_mem_test_master #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 89325,
    parameter int READ_LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [ADDR_W:0]      i_length,
    input  logic [DATA_W-1:0]    i_seed,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic                 o_range_err,
    output logic [ADDR_W:0]      o_err_count,
    output logic [ADDR_W-1:0]    o_first_err_addr,
    ativiade5_mem_test_master_if.master avm
);
    localparam int AW1 = ADDR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_len;
    logic [DATA_W-1:0]   r_seed;
    logic [ADDR_W:0]     r_addr, r_end;
    logic [ADDR_W:0]     r_err_count;
    logic [ADDR_W-1:0]   r_first_err;
    logic                r_pass, r_range_err;
    logic [READ_LATENCY-1:0] r_pv;
    logic [ADDR_W-1:0]   r_pa [READ_LATENCY];

    logic                w_cs, w_wr, w_accept, w_last, w_range_bad, w_pend, w_cmp, w_mis;
    logic [ADDR_W+1:0]   w_span;
    logic [DATA_W-1:0]   w_wdata, w_exp;
    logic [ADDR_W:0]     w_err_nxt;

    // Only the stage whose data is on readdata this cycle may still be valid when leaving DRAIN.
    localparam logic [READ_LATENCY-1:0] LAST_STAGE = READ_LATENCY'(1) << (READ_LATENCY - 1);

`ifdef MEMTEST_LFSR_EN
    logic [DATA_W-1:0] r_wgen, r_cgen;
    function automatic logic [DATA_W-1:0] f_lfsr(input logic [DATA_W-1:0] s);
        return s[0] ? ((s >> 1) ^ DATA_W'(32'h80200003)) : (s >> 1);
    endfunction
    assign w_wdata = r_wgen;
    assign w_exp   = r_cgen;
`else
    assign w_wdata = DATA_W'(r_addr[ADDR_W-1:0]) ^ r_seed;
    assign w_exp   = DATA_W'(r_pa[READ_LATENCY-1]) ^ r_seed;
`endif

    // Range test needs one bit beyond the address arithmetic so a huge length cannot wrap.
    assign w_span      = {2'b00, r_base} + {1'b0, r_len};
    assign w_range_bad = w_span > (ADDR_W+2)'(DEPTH);
    assign w_last      = (r_addr + AW1'(1)) == r_end;
    assign w_accept    = w_cs & ~avm.avm_waitrequest;
    assign w_pend      = |(r_pv & ~LAST_STAGE);
    assign w_cmp       = r_pv[READ_LATENCY-1];
    assign w_mis       = w_cmp & (avm.avm_readdata != w_exp);
    assign w_err_nxt   = r_err_count + AW1'(w_mis);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_cs        = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_CHECK;
            S_CHECK: begin
                o_busy      = 1'b1;
                w_state_nxt = (r_len == '0 || w_range_bad) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                o_busy = 1'b1;
                w_cs   = 1'b1;
                w_wr   = 1'b1;
                if (!avm.avm_waitrequest && w_last) w_state_nxt = S_READ;
            end
            S_READ: begin
                o_busy = 1'b1;
                w_cs   = 1'b1;
                if (!avm.avm_waitrequest && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (!w_pend) w_state_nxt = S_DONE;
            end
            S_DONE:  begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_base      <= '0;
            r_len       <= '0;
            r_seed      <= '0;
            r_addr      <= '0;
            r_end       <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
            r_range_err <= 1'b0;
            r_pv        <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_pa[i] <= '0;
`ifdef MEMTEST_LFSR_EN
            r_wgen      <= '0;
            r_cgen      <= '0;
`endif
        end else begin
            // Read-tracking pipeline: one entry per accepted read, compared when it falls out.
            r_pv[0] <= w_accept & ~w_wr;
            r_pa[0] <= r_addr[ADDR_W-1:0];
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_base      <= i_base_addr;
                    r_len       <= i_length;
                    r_seed      <= i_seed;
                    r_pass      <= 1'b0;
                    r_range_err <= 1'b0;
                end
                S_CHECK: begin
                    r_err_count <= '0;
                    r_first_err <= '0;
                    r_addr      <= {1'b0, r_base};
                    r_end       <= {1'b0, r_base} + r_len;
`ifdef MEMTEST_LFSR_EN
                    r_wgen      <= (r_seed == '0) ? DATA_W'(1) : r_seed;
                    r_cgen      <= (r_seed == '0) ? DATA_W'(1) : r_seed;
`endif
                    if (r_len == '0)      r_pass      <= 1'b1;
                    else if (w_range_bad) r_range_err <= 1'b1;
                end
                S_WRITE: if (w_accept) begin
                    r_addr <= w_last ? {1'b0, r_base} : r_addr + AW1'(1);
`ifdef MEMTEST_LFSR_EN
                    r_wgen <= f_lfsr(r_wgen);
`endif
                end
                S_READ:  if (w_accept) r_addr <= r_addr + AW1'(1);
                S_DRAIN: if (!w_pend) r_pass <= (w_err_nxt == '0);
                default: ;
            endcase
            if (w_cmp) begin
                r_err_count <= w_err_nxt;
                if (w_mis && r_err_count == '0) r_first_err <= r_pa[READ_LATENCY-1];
`ifdef MEMTEST_LFSR_EN
                r_cgen <= f_lfsr(r_cgen);
`endif
            end
        end
    end

    assign o_pass           = r_pass;
    assign o_range_err      = r_range_err;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err;

    assign avm.avm_chipselect = w_cs;
    assign avm.avm_write      = w_wr;
    assign avm.avm_address    = w_cs ? r_addr[ADDR_W-1:0] : '0;
    assign avm.avm_byteenable = w_cs ? '1 : '0;
    assign avm.avm_writedata  = w_wr ? w_wdata : '0;
    assign avm.avm_clken      = 1'b1;
endmodule

// File: tb/tb_ativiade5_mem_test_master.sv
// Bench for the memory test master: behavioural RAM slave, table of directed tests, randomized tests.
// Latency: RAM slave returns readdata one cycle after an accepted read.
// Backpressure: waitrequest optionally randomized per cycle.
module tb_ativiade5_mem_test_master;
    localparam int DEPTH = 89325;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] base_addr;
    logic [17:0] length;
    logic [31:0] seed;
    logic        busy, done, pass, range_err;
    logic [17:0] err_count;
    logic [16:0] first_err_addr;

    ativiade5_mem_test_master_if #(.ADDR_W(17), .DATA_W(32)) avm_if ();

    ativiade5_mem_test_master #(.ADDR_W(17), .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_base_addr(base_addr), .i_length(length),
        .i_seed(seed), .o_busy(busy), .o_done(done), .o_pass(pass), .o_range_err(range_err),
        .o_err_count(err_count), .o_first_err_addr(first_err_addr), .avm(avm_if.master)
    );

    always #5 clk = ~clk;

    int tests = 0, failed = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural RAM slave ----------------
    bit [31:0] ram  [DEPTH];
    bit        flip [DEPTH];
    int wr_cnt, rd_cnt, cs_seen, stall_bad, be_bad, oob, last_addr;
    bit        p_stall;
    logic [16:0] p_addr;
    logic        p_wr;
    logic [31:0] p_data;

    always @(posedge clk) begin
        if (avm_if.avm_byteenable != (avm_if.avm_chipselect ? 4'hF : 4'h0)) be_bad++;
        if (avm_if.avm_chipselect) begin
            cs_seen++;
            if (p_stall && (avm_if.avm_address != p_addr || avm_if.avm_write != p_wr ||
                            (p_wr && avm_if.avm_writedata != p_data))) stall_bad++;
            if (!avm_if.avm_waitrequest) begin
                if (int'(avm_if.avm_address) >= DEPTH) oob++;
                else if (avm_if.avm_write) begin
                    ram[avm_if.avm_address] = avm_if.avm_writedata;
                    wr_cnt++;
                end else begin
                    avm_if.avm_readdata <= ram[avm_if.avm_address] ^ {31'b0, flip[avm_if.avm_address]};
                    rd_cnt++;
                end
                last_addr = int'(avm_if.avm_address);
            end
            p_stall = avm_if.avm_waitrequest;
            p_addr  = avm_if.avm_address;
            p_wr    = avm_if.avm_write;
            p_data  = avm_if.avm_writedata;
        end else p_stall = 1'b0;
    end

    // ---------------- vectors and reference model ----------------
    typedef struct {
        int        base;
        int        len;
        bit [31:0] sd;
        int        flip0;
        int        flip1;
        bit        rw;
        bit        e_pass;
        bit        e_rerr;
        int        e_err;
        int        e_first;
        int        e_wr;
        int        e_rd;
    } vec_t;

    // Expected results straight from the test's rules: empty test passes, out-of-range is
    // rejected with no traffic, otherwise every flipped word in range is one error.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int lo = -1, n = 0;
        r.e_pass = 0; r.e_rerr = 0; r.e_err = 0; r.e_first = 0; r.e_wr = 0; r.e_rd = 0;
        if (v.len == 0) r.e_pass = 1;
        else if (v.base + v.len > DEPTH) r.e_rerr = 1;
        else begin
            r.e_wr = v.len;
            r.e_rd = v.len;
            for (int a = v.base; a < v.base + v.len; a++)
                if (a == v.flip0 || a == v.flip1) begin
                    n++;
                    if (lo < 0) lo = a;
                end
            r.e_err   = n;
            r.e_first = (lo < 0) ? 0 : lo;
            r.e_pass  = (n == 0);
        end
        return r;
    endfunction

    bit    got_pass, got_rerr, got_to;
    int    got_err, got_first, got_cyc;

    task automatic do_test(input vec_t v, input bit ign_start);
        for (int a = v.base; a < v.base + v.len && a < DEPTH; a++) ram[a] = $urandom;
        if (v.flip0 >= 0) flip[v.flip0] = 1'b1;
        if (v.flip1 >= 0) flip[v.flip1] = 1'b1;
        wr_cnt = 0; rd_cnt = 0; cs_seen = 0; stall_bad = 0; be_bad = 0; oob = 0; last_addr = -1;
        @(negedge clk);
        base_addr = 17'(v.base); length = 18'(v.len); seed = v.sd; start = 1'b1;
        avm_if.avm_waitrequest = v.rw ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        start = 1'b0;
        // inputs are only sampled at start; scramble them afterwards
        base_addr = 17'($urandom); length = 18'($urandom); seed = $urandom;
        got_cyc = 1;
        while (!done && got_cyc < 5000) begin
            start = (ign_start && got_cyc == 4);
            avm_if.avm_waitrequest = v.rw ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            got_cyc++;
        end
        start = 1'b0;
        avm_if.avm_waitrequest = 1'b0;
        got_to = !done; got_pass = pass; got_rerr = range_err;
        got_err = int'(err_count); got_first = int'(first_err_addr);
        if (v.flip0 >= 0) flip[v.flip0] = 1'b0;
        if (v.flip1 >= 0) flip[v.flip1] = 1'b0;
    endtask

    task automatic check_test(input vec_t v, input int idx);
        int bad = 0;
        string t = $sformatf("t%0d_", idx);
        chk({t, "timeout"}, got_to, 0);
        chk({t, "pass"}, got_pass, v.e_pass);
        chk({t, "range_err"}, got_rerr, v.e_rerr);
        chk({t, "err_count"}, got_err, v.e_err);
        chk({t, "first_err"}, got_first, v.e_first);
        chk({t, "writes"}, wr_cnt, v.e_wr);
        chk({t, "reads"}, rd_cnt, v.e_rd);
        chk({t, "stall_stable"}, stall_bad, 0);
        chk({t, "byteenable"}, be_bad, 0);
        chk({t, "oob"}, oob, 0);
        if (v.e_wr > 0) begin
            for (int a = v.base; a < v.base + v.len; a++) if (ram[a] != (32'(a) ^ v.sd)) bad++;
            chk({t, "ram_content"}, bad, 0);
        end else chk({t, "no_chipselect"}, cs_seen, 0);
        if (v.len == 0) chk({t, "len0_latency"}, got_cyc, 2);
    endtask

    vec_t vt[$];

    initial begin
        vec_t v;
        int   n0;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0;
        avm_if.avm_waitrequest = 1'b0; avm_if.avm_readdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cs", avm_if.avm_chipselect, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", first_err_addr, 0);
        chk("rst_addr", avm_if.avm_address, 0);
        chk("rst_clken", avm_if.avm_clken, 1);

        //          base   len  seed          flip0 flip1 rw pass rerr err first  wr  rd
        vt.push_back('{0,     16, 32'hA5A5A5A5, -1,   -1,   0, 1,   0,   0,  0,     16, 16});
        vt.push_back('{0,     16, 32'hA5A5A5A5, 5,    -1,   0, 0,   0,   1,  5,     16, 16});
        vt.push_back('{0,     0,  32'h12345678, -1,   -1,   0, 1,   0,   0,  0,     0,  0});
        vt.push_back('{89320, 6,  32'h0F0F0F0F, -1,   -1,   0, 0,   1,   0,  0,     0,  0});
        vt.push_back('{89320, 5,  32'h0F0F0F0F, -1,   -1,   0, 1,   0,   0,  0,     5,  5});
        vt.push_back('{0,     32, 32'hDEADBEEF, -1,   -1,   1, 1,   0,   0,  0,     32, 32});
        vt.push_back('{1000,  20, 32'h00000000, 1010, 1003, 1, 0,   0,   2,  1003,  20, 20});
        for (int k = 0; k < 8; k++) begin
            v.base  = $urandom_range(0, 1) ? DEPTH - int'($urandom_range(1, 45)) : int'($urandom_range(0, DEPTH - 50));
            v.len   = $urandom_range(0, 40);
            v.sd    = $urandom;
            v.rw    = 1'($urandom_range(0, 1));
            v.flip0 = -1; v.flip1 = -1;
            if (v.len > 0 && v.base + v.len <= DEPTH) begin
                if ($urandom_range(0, 1)) v.flip0 = v.base + int'($urandom_range(0, v.len - 1));
                if ($urandom_range(0, 2) == 0) v.flip1 = v.base + int'($urandom_range(0, v.len - 1));
            end
            vt.push_back(model(v));
        end

        foreach (vt[i]) begin
            do_test(vt[i], 1'b0);
            check_test(vt[i], i);
            if (vt[i].base == 89320 && vt[i].len == 5) chk("last_addr_89324", last_addr, 89324);
        end

        // start pulses while busy and during DONE must be ignored
        v = model('{200, 24, 32'h55AA55AA, 210, -1, 1, 0, 0, 0, 0, 0, 0});
        do_test(v, 1'b1);
        check_test(v, 99);
        start = 1'b1; base_addr = 17'd0; length = 18'd4;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", busy, 0);
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        chk("pass_held", pass, 0);

        // reset in the middle of the write phase
        wr_cnt = 0;
        @(negedge clk);
        base_addr = 17'd100; length = 18'd50; seed = 32'h13572468; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n0 = 0;
        while (wr_cnt < 7 && n0 < 200) begin
            @(negedge clk);
            n0++;
        end
        chk("rst_mid_reach_w7", wr_cnt, 7);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cs", avm_if.avm_chipselect, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_write", avm_if.avm_write, 0);
        chk("rst_mid_addr", avm_if.avm_address, 0);
        chk("rst_mid_wdata", avm_if.avm_writedata, 0);
        chk("rst_mid_be", avm_if.avm_byteenable, 0);
        chk("rst_mid_err_count", err_count, 0);
        rst = 1'b0;
        n0 = cs_seen;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_xfer", cs_seen - n0, 0);
        chk("rst_mid_idle", busy, 0);

        // normal operation after the abort
        v = model('{4000, 12, 32'hCAFEF00D, 4011, -1, 0, 0, 0, 0, 0, 0, 0});
        do_test(v, 1'b0);
        check_test(v, 100);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
